// File: rtl/mem_bist_pkg.sv
// Shared types and March C- element tables for the BIST memory block.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package mem_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef enum logic {
        PH_RD,
        PH_WR
    } phase_t;

    // Element encoding in march order.
    localparam logic [2:0] ELEM_W0      = 3'd0;  // up   (w D0)
    localparam logic [2:0] ELEM_R0W1    = 3'd1;  // up   (r D0, w D1)
    localparam logic [2:0] ELEM_R1W0    = 3'd2;  // up   (r D1, w D0)
    localparam logic [2:0] ELEM_R0W1_DN = 3'd3;  // down (r D0, w D1)
    localparam logic [2:0] ELEM_R1W0_DN = 3'd4;  // down (r D1, w D0)
    localparam logic [2:0] ELEM_R0      = 3'd5;  // down (r D0)

    // 1 = element walks addresses N-1..0.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == ELEM_R0W1_DN) || (e == ELEM_R1W0_DN) || (e == ELEM_R0);
    endfunction

    function automatic logic elem_has_rd(input logic [2:0] e);
        return e != ELEM_W0;
    endfunction

    function automatic logic elem_has_wr(input logic [2:0] e);
        return e != ELEM_R0;
    endfunction

    // Polarity of the expected read data: 0 = background, 1 = inverted background.
    function automatic logic elem_rd_pol(input logic [2:0] e);
        return (e == ELEM_R1W0) || (e == ELEM_R1W0_DN);
    endfunction

    // Polarity of the written data: 0 = background, 1 = inverted background.
    function automatic logic elem_wr_pol(input logic [2:0] e);
        return (e == ELEM_R0W1) || (e == ELEM_R0W1_DN);
    endfunction

endpackage

// File: rtl/mem_bist_array.sv
// Single-port flop array with stuck-at-1 fault injection on bit 0 of one word.
// Latency: write takes effect at the clock edge; rdata is registered (1 cycle, read-before-write).
// Backpressure: none; one access accepted every cycle.
module mem_bist_array #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 fault_en,
    input  logic [ADDR_BITS-1:0] fault_addr,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] wdata_eff;

    // Faulty word: bit 0 always stores 1, whichever side owns the port.
    always_comb begin
        wdata_eff = wdata;
        if (fault_en && (addr == fault_addr)) begin
            wdata_eff[0] = 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata_eff;
        end
    end

    // Registered read of the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_march_bist.sv
// RAM with a March C- self-test engine; pins own the array when idle, the engine when busy.
// Latency: direct read 1 cycle; a BIST run holds busy for 10N+1 cycles after start.
// Backpressure: none; start and direct accesses are ignored while busy.
module mem_march_bist
    import mem_bist_pkg::*;
#(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 8,
    parameter int ERR_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] bg,
    input  logic                 fault_en,
    input  logic [ADDR_BITS-1:0] fault_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_BITS-1:0]  err_count,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [2:0]           fail_elem
);

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ERR_BITS-1:0]  ERR_MAX  = '1;
    localparam logic [ERR_BITS-1:0]  ERR_ONE  = {{(ERR_BITS-1){1'b0}}, 1'b1};

    state_t               state;
    logic [2:0]           elem;
    phase_t               phase;
    logic [ADDR_BITS-1:0] acnt;
    logic [DATA_BITS-1:0] bg_q;

    // Compare stage: tag of the read issued in the previous cycle.
    logic                 cmp_vld;
    logic [DATA_BITS-1:0] cmp_exp;
    logic [2:0]           cmp_elem;
    logic [ADDR_BITS-1:0] cmp_addr;

    logic                 arr_we;
    logic [ADDR_BITS-1:0] arr_addr;
    logic [DATA_BITS-1:0] arr_wdata;

    logic                 last_addr;
    logic [2:0]           elem_nxt;
    logic [ADDR_BITS-1:0] start_nxt;
    logic                 mismatch;
    logic [ERR_BITS-1:0]  err_next;

    // Array port ownership: the engine takes over for the whole busy window.
    always_comb begin
        arr_we    = we;
        arr_addr  = addr;
        arr_wdata = wdata;
        if (busy) begin
            arr_we    = (state == RUN) && (phase == PH_WR);
            arr_addr  = acnt;
            arr_wdata = elem_wr_pol(elem) ? ~bg_q : bg_q;
        end
    end

    // Address sequencing and error accounting helpers.
    always_comb begin
        last_addr = elem_down(elem) ? (acnt == '0) : (acnt == ADDR_MAX);
        elem_nxt  = elem + 3'd1;
        start_nxt = elem_down(elem_nxt) ? ADDR_MAX : '0;
        mismatch  = cmp_vld && (rdata != cmp_exp);
        err_next  = (mismatch && (err_count != ERR_MAX)) ? err_count + ERR_ONE : err_count;
    end

    mem_bist_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (arr_we),
        .addr       (arr_addr),
        .wdata      (arr_wdata),
        .fault_en   (fault_en),
        .fault_addr (fault_addr),
        .rdata      (rdata)
    );

    // Engine FSM: march sequencing, compare tagging and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            elem      <= ELEM_W0;
            phase     <= PH_WR;
            acnt      <= '0;
            bg_q      <= '0;
            cmp_vld   <= 1'b0;
            cmp_exp   <= '0;
            cmp_elem  <= '0;
            cmp_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            cmp_vld <= 1'b0;
            if (mismatch) begin
                err_count <= err_next;
                if (err_count == '0) begin
                    fail_addr <= cmp_addr;
                    fail_elem <= cmp_elem;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        bg_q      <= bg;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                        elem      <= ELEM_W0;
                        phase     <= PH_WR;
                        acnt      <= '0;
                    end
                end
                RUN: begin
                    if (phase == PH_RD) begin
                        cmp_vld  <= 1'b1;
                        cmp_exp  <= elem_rd_pol(elem) ? ~bg_q : bg_q;
                        cmp_elem <= elem;
                        cmp_addr <= acnt;
                    end
                    if ((phase == PH_RD) && elem_has_wr(elem)) begin
                        phase <= PH_WR;
                    end else if (last_addr) begin
                        if (elem == ELEM_R0) begin
                            state <= DRAIN;
                        end else begin
                            elem  <= elem_nxt;
                            acnt  <= start_nxt;
                            phase <= PH_RD;
                        end
                    end else begin
                        acnt  <= elem_down(elem) ? acnt - ADDR_ONE : acnt + ADDR_ONE;
                        phase <= elem_has_rd(elem) ? PH_RD : PH_WR;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
